// File: rtl/ice_rst_pkg.sv
// Shared reset-sequencing types and defaults.
// Other reset-aware blocks reuse the timing constants.
package ice_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_GAP  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/rst_seq_if.sv
// Control/status bundle of the reset sequencer.
// master = requester side, slave = sequencer side.
interface rst_seq_if #(
  parameter int NUM_STAGES = 3
);

  logic                  soft_req;
  logic                  hold;
  logic [NUM_STAGES-1:0] rst_out_n;
  logic                  seq_done;
  logic                  busy;
  logic                  soft_ack;

  modport master (
    output soft_req, hold,
    input  rst_out_n, seq_done, busy, soft_ack
  );

  modport slave (
    input  soft_req, hold,
    output rst_out_n, seq_done, busy, soft_ack
  );

endinterface

// File: rtl/rst_seq.sv
// Ordered release of active-low reset domains.
// Hold period, then one domain per gap; soft restart.
module rst_seq
  import ice_rst_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     reset_n,
  rst_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0] IDX_LAST =
    4'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE =
    NUM_STAGES'(1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Next state: soft_req restarts from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ack_d   = bus.soft_req;
    if (bus.soft_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (bus.hold) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            idx_d = 4'd1;
            rst_d = rst_q | ONE;
            if (NUM_STAGES == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 4'd1;
            rst_d = rst_q | (ONE << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign bus.rst_out_n = rst_q;
  assign bus.seq_done  = done_q;
  assign bus.busy      = busy_q;
  assign bus.soft_ack  = ack_q;

endmodule
